// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: records register-writeback commits (cycle stamp, PC, rd, data)
// into a circular buffer during a cycle-budgeted run, and drains them through a
// first-word-fall-through readout port.
//
// Readout handshake: rd_valid_o is high whenever at least one entry is held and
// rd_* show the oldest entry; the entry is consumed on a rising clk_i edge where
// rd_valid_o && rd_ready_i. rd_ready_i while rd_valid_o is low has no effect.
// rd_valid_o never depends combinationally on rd_ready_i or on the commit inputs.
module commit_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 30,
  parameter int WRAP       = 0,
  parameter int FILTER_X0  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       commit_valid_i,
  input  logic [31:0]                commit_pc_i,
  input  logic [4:0]                 commit_rd_i,
  input  logic [31:0]                commit_data_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [CYCLE_W-1:0]         rd_cycle_o,
  output logic [31:0]                rd_pc_o,
  output logic [4:0]                 rd_rd_o,
  output logic [31:0]                rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CYCLE_W-1:0]         cycle_o,
  output logic                       overflow_o,
  output logic                       done_o,
  output logic [1:0]                 state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit HAS_BUDGET = (MAX_CYCLES != 0);
  localparam bit WRAP_B = (WRAP != 0);
  localparam bit FILTER_B = (FILTER_X0 != 0);
  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;

  logic [CYCLE_W-1:0] mem_cycle [DEPTH];
  logic [31:0]        mem_pc    [DEPTH];
  logic [4:0]         mem_rd    [DEPTH];
  logic [31:0]        mem_data  [DEPTH];

  logic active;      // this edge is a counted run cycle
  logic last_cycle;  // this active cycle exhausts the budget
  logic push;        // a commit qualifies for capture
  logic pop;         // consumer takes the head entry
  logic full;
  logic wr_en;       // the captured entry is actually stored
  logic rd_adv;      // read pointer moves (pop or overwrite of oldest)
  logic lost;        // an entry is dropped or overwrites the oldest

  // Capture/readout qualifiers; the IDLE edge that sees start_i is run cycle 0.
  always_comb begin
    active     = (state_q != S_DONE) && start_i;
    last_cycle = HAS_BUDGET && (cycle_q == LAST_CYCLE);
    push       = active && commit_valid_i && (!FILTER_B || (commit_rd_i != 5'd0));
    pop        = (count_q != '0) && rd_ready_i;
    full       = (count_q == FULL_COUNT);
    wr_en      = push && (!full || pop || WRAP_B);
    rd_adv     = pop || (push && full && WRAP_B);
    lost       = push && full && !pop;
  end

  // Run-control next state: start_i gates progress, budget ends capture for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = last_cycle ? S_DONE : S_RUN;
      S_RUN:   if (start_i && last_cycle) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: state, cycle counter, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (active) cycle_q <= cycle_q + CYCLE_W'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_adv) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en && rd_adv) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (lost) overflow_q <= 1'b1;
    end
  end

  // Trace storage; contents need no reset since count_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_cycle[wr_ptr_q] <= cycle_q;
      mem_pc[wr_ptr_q]    <= commit_pc_i;
      mem_rd[wr_ptr_q]    <= commit_rd_i;
      mem_data[wr_ptr_q]  <= commit_data_i;
    end
  end

  // Head entry straight from storage; forced to zero while empty so reset clears it.
  always_comb begin
    rd_valid_o = (count_q != '0);
    rd_cycle_o = rd_valid_o ? mem_cycle[rd_ptr_q] : '0;
    rd_pc_o    = rd_valid_o ? mem_pc[rd_ptr_q]    : '0;
    rd_rd_o    = rd_valid_o ? mem_rd[rd_ptr_q]    : '0;
    rd_data_o  = rd_valid_o ? mem_data[rd_ptr_q]  : '0;
    count_o    = count_q;
    cycle_o    = cycle_q;
    overflow_o = overflow_q;
    done_o     = (state_q == S_DONE);
    state_o    = state_q;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retire-event tracer for the pipelined RISC-V CPU.
- Captures register-writeback commits into a circular buffer. Each commit is stored as a tuple: cycle stamp, PC, rd, data.
- Ends capture after a configurable cycle budget and exposes a first-word-fall-through (FWFT) ready/valid readout port.
- Sits beside the MEM/WB stage. It is the in-hardware generalisation of our per-cycle simulation dump, and replaces it for long runs and FPGA bring-up.

Parameters:
- DEPTH, 16, number of trace entries; power of two, ≥2.
- CYCLE_W, 16, width of the cycle counter and cycle stamp.
- MAX_CYCLES, 30, capture budget in RUN cycles; 0 = unlimited.
- WRAP, 0, full-buffer policy. 0 = drop new entry. 1 = overwrite oldest entry.
- FILTER_X0, 1, when 1, commits with rd==0 are ignored.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  level enable. High = capture and count; low = pause.
- commit_valid_i  in  1  a writeback commits this cycle.
- commit_pc_i  in  32  PC of the committing instruction.
- commit_rd_i  in  5  destination register.
- commit_data_i  in  32  writeback value.
- rd_ready_i  in  1  consumer accepts the head entry.
- rd_valid_o  out  1  head entry valid.
- rd_cycle_o  out  CYCLE_W  head cycle stamp.
- rd_pc_o  out  32  head PC.
- rd_rd_o  out  5  head rd.
- rd_data_o  out  32  head data.
- count_o  out  $clog2(DEPTH)+1  number of entries held.
- cycle_o  out  CYCLE_W  current RUN cycle count.
- overflow_o  out  1  sticky: an entry was dropped or overwritten.
- done_o  out  1  capture budget exhausted.

Behaviour:
- Reset (rst_i low, async): state=IDLE; pointers, count_o, cycle_o, overflow_o, done_o all 0; rd_valid_o=0. Buffer contents are don't-care.
- States:
  - IDLE: start_i sampled high at a clock edge → RUN. That edge also counts as RUN cycle 0 and may capture.
  - RUN: each edge with start_i=1 is one active cycle.
    - The entry captured on an active cycle is stamped with the pre-increment cycle_o value.
    - cycle_o then increments; it wraps mod 2^CYCLE_W.
    - Edges with start_i=0 are paused: no capture, no increment, state held.
    - If MAX_CYCLES≠0 and the active cycle's cycle_o==MAX_CYCLES-1, that cycle still captures, then state → DONE.
  - DONE: done_o=1 and cycle_o frozen. No further capture. Readout continues. Only reset leaves DONE.
- Capture condition: state RUN, start_i=1, commit_valid_i=1, and (FILTER_X0=0 or commit_rd_i≠0).
- Readout (FWFT):
  - rd_valid_o = (count_o≠0).
  - rd_* always show the oldest entry, registered, with no extra read latency.
  - Pop on rd_valid_o & rd_ready_i.
  - rd_ready_i with empty buffer: no effect.
- Push and pop in the same cycle: both occur; count_o unchanged. This applies when full, in either WRAP mode.
- Full (count_o==DEPTH), push without pop:
  - WRAP=0: entry discarded, overflow_o←1.
  - WRAP=1: entry written over the oldest; read pointer advances; count stays DEPTH; overflow_o←1.
- Empty with simultaneous push: entry becomes visible on rd_valid_o the following cycle, never combinationally.
- overflow_o clears only on reset.
- Pointers wrap mod DEPTH.
- Inputs outside the capture condition are ignored; X on them must not corrupt state.

Test Plan:
- Reset, start_i=1, commit every cycle with rd=1..5, pc=0,4,8,12,16, data=10..14, rd_ready_i=0.
  → count_o=5; head shows cycle 0, pc 0, rd 1, data 10.
  → Pop 5 times: cycles 0..4 returned in order; rd_valid_o then 0.
- MAX_CYCLES=30, continuous commits, DEPTH=64.
  → done_o rises after the 30th active edge; cycle_o=30; exactly 30 entries; last stamp 29.
  → commit_valid_i held high afterwards does not change count_o.
- DEPTH=4, WRAP=0, 6 commits, no pops.
  → count_o=4; entries hold stamps 0..3; overflow_o=1.
  → Repeat with WRAP=1: entries hold stamps 2..5; head stamp 2; overflow_o=1.
- FILTER_X0=1: commits with rd=0, rd=7, rd=0.
  → Only the rd=7 entry is stored, stamped 1.
- Buffer full (DEPTH=4) with rd_ready_i=1 and a commit in the same cycle.
  → count_o stays 4; overflow_o stays 0; the popped entry is the oldest.
- Mid-run: start_i low for 3 cycles, then rst_i pulsed low asynchronously between edges.
  → cycle_o and count_o hold during the pause.
  → On the reset pulse, all outputs 0 immediately, without waiting for a clock edge.
  → After release, the next start_i-high edge is stamped cycle 0.
